// File: rtl/pipe_stall_if.sv
// Pipeline-control bundle: hazard/memory status from the core (master) and the
// per-stage enables, flush/bubble controls and status returned by the controller (slave).
interface pipe_stall_if #(
    parameter int unsigned CNT_W = 16
);
    logic             load_to_stall;
    logic             brstall;
    logic             br_resolve;
    logic             br_taken;
    logic             imem_stall;
    logic             dmem_stall;
    logic             halt_wb;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_we;
    logic             id_ex_bubble;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             halted;
    logic             br_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output load_to_stall, brstall, br_resolve, br_taken, imem_stall, dmem_stall, halt_wb,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we,
        input  halted, br_err, stall_cycles
    );

    modport slave (
        input  load_to_stall, brstall, br_resolve, br_taken, imem_stall, dmem_stall, halt_wb,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we,
        output halted, br_err, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: branch-wait FSM, halt
// sequencing, saturating stall-cycle counter and branch-timeout error flag.
module pipe_stall_ctrl #(
    parameter int unsigned BR_MAX = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_stall_if.slave   io_bus
);
    localparam int unsigned BCW = $clog2(BR_MAX + 1);
    localparam logic [BCW-1:0] BrMaxC = BCW'(BR_MAX);

    typedef enum logic [1:0] {StRun, StBrWait, StBrFlush, StHalted} state_e;

    state_e           r_state;
    state_e           w_state_d;
    logic [BCW-1:0]   r_br_cnt;
    logic [BCW-1:0]   w_br_cnt_d;
    logic             r_br_err;
    logic             w_br_err_d;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_pc_we;
    logic w_if_id_we;
    logic w_if_id_flush;
    logic w_id_ex_we;
    logic w_id_ex_bubble;
    logic w_ex_mem_we;
    logic w_mem_wb_we;

    always_comb begin
        w_state_d      = r_state;
        w_br_cnt_d     = r_br_cnt;
        w_br_err_d     = r_br_err;
        w_pc_we        = 1'b1;
        w_if_id_we     = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_we     = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_we    = 1'b1;
        w_mem_wb_we    = 1'b1;

        if (r_state == StHalted || (io_bus.dmem_stall && !io_bus.halt_wb)) begin
            // Halted, or frozen on data memory: nothing moves and no state advances.
            w_pc_we     = 1'b0;
            w_if_id_we  = 1'b0;
            w_id_ex_we  = 1'b0;
            w_ex_mem_we = 1'b0;
            w_mem_wb_we = 1'b0;
        end else if (io_bus.halt_wb) begin
            w_state_d = StHalted;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (io_bus.load_to_stall || io_bus.brstall) begin
                        w_pc_we        = 1'b0;
                        w_if_id_we     = 1'b0;
                        w_id_ex_bubble = 1'b1;
                        if (!io_bus.load_to_stall) begin
                            w_state_d  = StBrWait;
                            w_br_cnt_d = BCW'(1);
                        end
                    end else if (io_bus.imem_stall) begin
                        w_pc_we       = 1'b0;
                        w_if_id_flush = 1'b1;
                    end
                end
                StBrWait: begin
                    w_if_id_we     = 1'b0;
                    w_id_ex_bubble = 1'b1;
                    if (io_bus.br_resolve) begin
                        w_br_cnt_d = '0;
                        if (io_bus.br_taken) begin
                            w_state_d = StBrFlush;
                        end else begin
                            w_if_id_we     = 1'b1;
                            w_id_ex_bubble = 1'b0;
                            w_state_d      = StRun;
                        end
                    end else begin
                        w_pc_we = 1'b0;
                        if (r_br_cnt == BrMaxC) begin
                            w_br_err_d = 1'b1;
                        end else begin
                            w_br_cnt_d = r_br_cnt + 1'b1;
                        end
                    end
                end
                StBrFlush: begin
                    // IF/ID holds the wrong-path fetch; its hazards are irrelevant.
                    w_if_id_flush = 1'b1;
                    w_pc_we       = !io_bus.imem_stall;
                    w_state_d     = StRun;
                    w_br_cnt_d    = '0;
                end
                StHalted: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_br_cnt    <= '0;
            r_br_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_d;
            r_br_cnt <= w_br_cnt_d;
            r_br_err <= w_br_err_d;
            if (!w_pc_we && r_state != StHalted && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Enables are forced low for as long as reset is asserted.
    assign io_bus.pc_we        = rst_n & w_pc_we;
    assign io_bus.if_id_we     = rst_n & w_if_id_we;
    assign io_bus.if_id_flush  = rst_n & w_if_id_flush;
    assign io_bus.id_ex_we     = rst_n & w_id_ex_we;
    assign io_bus.id_ex_bubble = rst_n & w_id_ex_bubble;
    assign io_bus.ex_mem_we    = rst_n & w_ex_mem_we;
    assign io_bus.mem_wb_we    = rst_n & w_mem_wb_we;
    assign io_bus.halted       = (r_state == StHalted);
    assign io_bus.br_err       = r_br_err;
    assign io_bus.stall_cycles = r_stall_cnt;
endmodule
